// File: rtl/nand_phy_rd_calib.sv
// Read-capture calibration sequencer for one NAND DQ byte lane.
// It requests a training read and scores the 0/90/180/270 phase samples
// against an alternating 0x00/0xFF pattern. It then picks the clk0 capture
// phase (0 or 180) and releases or re-asserts the lane's IDDR reset.
module nand_phy_rd_calib #(
    parameter int unsigned DQ_WIDTH    = 8,
    parameter int unsigned N_SAMPLES   = 64,
    parameter int unsigned SKIP_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned PASS_THRESH = 56
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic                calib_start,
    output logic                calib_rd_req,
    input  logic                calib_rd_valid,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_0,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_90,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_180,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_270,
    output logic                dq_iddr_rst,
    output logic                calib_clk0_sel,
    output logic                calib_busy,
    output logic                calib_done,
    output logic [1:0]          calib_err,
    output logic [7:0]          score_0,
    output logic [7:0]          score_90,
    output logic [7:0]          score_180,
    output logic [7:0]          score_270
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_SKIP, S_SCORE, S_DECIDE, S_FAIL, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       tmo_cnt;
    logic [3:0]          skip_cnt;
    logic [7:0]          smp_cnt;
    logic [DQ_WIDTH-1:0] prev_0, prev_90, prev_180, prev_270;
    logic [7:0]          win_score;

    // A sample scores when all bits agree and it is the inverse of the previous one.
    function automatic logic is_hit(input logic [DQ_WIDTH-1:0] s, input logic [DQ_WIDTH-1:0] p);
        return ((s == '0) || (s == '1)) && (s == ~p);
    endfunction

    // Saturating score increment.
    function automatic logic [7:0] bump(input logic [7:0] sc, input logic h);
        return (h && (sc != 8'hFF)) ? sc + 8'd1 : sc;
    endfunction

    assign win_score = (score_0 >= score_180) ? score_0 : score_180;

    // State register.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. The valid cycle that leaves WAIT only marks the start
    // of the read stream; SKIP then discards SKIP_CYCLES further valid cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (calib_start) state_nxt = S_ARM;
            S_ARM:          state_nxt = S_WAIT;
            S_WAIT: begin
                if (calib_rd_valid)
                    state_nxt = (SKIP_CYCLES == 0) ? S_SCORE : S_SKIP;
                else if (tmo_cnt == TW'(TIMEOUT - 1))
                    state_nxt = S_FAIL;
            end
            S_SKIP: if (calib_rd_valid && (skip_cnt == 4'(SKIP_CYCLES - 1))) state_nxt = S_SCORE;
            S_SCORE: begin
                if (!calib_rd_valid)
                    state_nxt = S_FAIL;
                else if (smp_cnt == 8'(N_SAMPLES - 1))
                    state_nxt = S_DECIDE;
            end
            S_DECIDE, S_FAIL: state_nxt = S_DONE;
            default:          state_nxt = S_IDLE;
        endcase
    end

    // Datapath: counters, scoring, phase decision and lane control outputs.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            calib_rd_req   <= 1'b0;
            dq_iddr_rst    <= 1'b1;
            calib_clk0_sel <= 1'b1;
            calib_busy     <= 1'b0;
            calib_done     <= 1'b0;
            calib_err      <= 2'b00;
            score_0        <= '0;
            score_90       <= '0;
            score_180      <= '0;
            score_270      <= '0;
            prev_0         <= '0;
            prev_90        <= '0;
            prev_180       <= '0;
            prev_270       <= '0;
            tmo_cnt        <= '0;
            skip_cnt       <= '0;
            smp_cnt        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (calib_start) begin
                        calib_busy <= 1'b1;
                        calib_done <= 1'b0;
                        calib_err  <= 2'b00;
                        score_0    <= '0;
                        score_90   <= '0;
                        score_180  <= '0;
                        score_270  <= '0;
                        prev_0     <= '0;
                        prev_90    <= '0;
                        prev_180   <= '0;
                        prev_270   <= '0;
                        tmo_cnt    <= '0;
                        skip_cnt   <= '0;
                        smp_cnt    <= '0;
                    end
                end
                S_ARM: begin
                    dq_iddr_rst  <= 1'b0;
                    calib_rd_req <= 1'b1;
                end
                S_WAIT: begin
                    if (!calib_rd_valid) begin
                        if (tmo_cnt == TW'(TIMEOUT - 1)) calib_err <= 2'b01;
                        else                             tmo_cnt   <= tmo_cnt + 1'b1;
                    end
                end
                S_SKIP: begin
                    if (calib_rd_valid) begin
                        skip_cnt <= skip_cnt + 4'd1;
                        prev_0   <= calib_dq_rise_0;
                        prev_90  <= calib_dq_rise_90;
                        prev_180 <= calib_dq_rise_180;
                        prev_270 <= calib_dq_rise_270;
                    end
                end
                S_SCORE: begin
                    if (!calib_rd_valid) begin
                        calib_err <= 2'b10;
                    end else begin
                        score_0   <= bump(score_0,   is_hit(calib_dq_rise_0,   prev_0));
                        score_90  <= bump(score_90,  is_hit(calib_dq_rise_90,  prev_90));
                        score_180 <= bump(score_180, is_hit(calib_dq_rise_180, prev_180));
                        score_270 <= bump(score_270, is_hit(calib_dq_rise_270, prev_270));
                        prev_0    <= calib_dq_rise_0;
                        prev_90   <= calib_dq_rise_90;
                        prev_180  <= calib_dq_rise_180;
                        prev_270  <= calib_dq_rise_270;
                        smp_cnt   <= smp_cnt + 8'd1;
                    end
                end
                S_DECIDE: begin
                    calib_rd_req <= 1'b0;
                    calib_busy   <= 1'b0;
                    calib_done   <= 1'b1;
                    if (win_score >= 8'(PASS_THRESH)) begin
                        calib_clk0_sel <= (score_0 >= score_180);
                        calib_err      <= 2'b00;
                    end else begin
                        calib_err      <= 2'b11;
                    end
                end
                S_FAIL: begin
                    calib_rd_req <= 1'b0;
                    dq_iddr_rst  <= 1'b1;
                    calib_busy   <= 1'b0;
                    calib_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_phy_rd_calib.sv
// Self-checking bench for nand_phy_rd_calib: directed table of phase patterns,
// hand-written timeout / valid-drop / reset sequences, and randomized reads
// checked against a per-phase scoring model of the training stream.
module tb_nand_phy_rd_calib;

    localparam int DW   = 8;
    localparam int N    = 64;
    localparam int SKIP = 4;
    localparam int TMO  = 1023;
    localparam int THR  = 56;
    localparam int L    = 1 + SKIP + N;   // stream: start marker, skipped, scored

    localparam int K_ALT    = 0;  // clean 0x00/0xFF alternation
    localparam int K_MIX    = 1;  // constant mixed-bit value 0x0F
    localparam int K_CONST  = 2;  // constant 0xFF, never toggles
    localparam int K_GLITCH = 3;  // alternation with 10 mixed-bit glitches
    localparam int K_RAND   = 4;  // alternation with random corruption

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          calib_start;
    logic          calib_rd_req;
    logic          calib_rd_valid;
    logic [DW-1:0] rise_0, rise_90, rise_180, rise_270;
    logic          dq_iddr_rst;
    logic          calib_clk0_sel;
    logic          calib_busy;
    logic          calib_done;
    logic [1:0]    calib_err;
    logic [7:0]    score_0, score_90, score_180, score_270;

    nand_phy_rd_calib #(
        .DQ_WIDTH(DW), .N_SAMPLES(N), .SKIP_CYCLES(SKIP), .TIMEOUT(TMO), .PASS_THRESH(THR)
    ) dut (
        .clk0(clk0), .rst0(rst0), .calib_start(calib_start), .calib_rd_req(calib_rd_req),
        .calib_rd_valid(calib_rd_valid), .calib_dq_rise_0(rise_0), .calib_dq_rise_90(rise_90),
        .calib_dq_rise_180(rise_180), .calib_dq_rise_270(rise_270), .dq_iddr_rst(dq_iddr_rst),
        .calib_clk0_sel(calib_clk0_sel), .calib_busy(calib_busy), .calib_done(calib_done),
        .calib_err(calib_err), .score_0(score_0), .score_90(score_90), .score_180(score_180),
        .score_270(score_270)
    );

    always #5 clk0 = ~clk0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] stream [0:3][0:L-1];
    int         pre    [0:3][0:L];
    logic       model_sel;
    int         rand_rate;

    typedef struct {
        int         k0, k90, k180, k270;
        int         e_s0, e_s180;
        logic       e_sel;
        logic [1:0] e_err;
    } vec_t;
    vec_t tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_score(input int p);
        case (p)
            0:       return score_0;
            1:       return score_90;
            2:       return score_180;
            default: return score_270;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int kind, input int k);
        logic [7:0] alt;
        int         j;
        alt = (k % 2 == 0) ? 8'h00 : 8'hFF;
        j   = k - 1 - SKIP;
        case (kind)
            K_ALT:    return alt;
            K_MIX:    return 8'h0F;
            K_CONST:  return 8'hFF;
            K_GLITCH: return (j >= 0 && j < 40 && j % 4 == 2) ? 8'h0F : alt;
            default:  return ($urandom_range(0, rand_rate - 1) == 0) ? 8'($urandom_range(0, 255)) : alt;
        endcase
    endfunction

    task automatic fill(input int k0, input int k90, input int k180, input int k270);
        for (int k = 0; k < L; k++) begin
            stream[0][k] = pat(k0, k);
            stream[1][k] = pat(k90, k);
            stream[2][k] = pat(k180, k);
            stream[3][k] = pat(k270, k);
        end
    endtask

    // Expected running score per phase after the first n stream entries.
    task automatic model(input int n_drive);
        logic [7:0] s, pv;
        int acc;
        for (int p = 0; p < 4; p++) begin
            acc = 0;
            pre[p][0] = 0;
            for (int k = 0; k < L; k++) begin
                if (k < n_drive && k >= 1 + SKIP) begin
                    s  = stream[p][k];
                    pv = (k >= 2) ? stream[p][k-1] : 8'h00;
                    if ((s == 8'h00 || s == 8'hFF) && s == ~pv && acc < 255) acc++;
                end
                pre[p][k+1] = acc;
            end
        end
    endtask

    task automatic pulse_start_and_check;
        @(negedge clk0); calib_start = 1'b1;
        @(negedge clk0); calib_start = 1'b0;
        chk("req_lat1", calib_rd_req, 0);
        chk("busy_set", calib_busy, 1);
        chk("done_clr", calib_done, 0);
        @(negedge clk0);
        chk("req_lat2", calib_rd_req, 1);
        chk("iddr_rel", dq_iddr_rst, 0);
    endtask

    // One training read: n_drive stream entries with valid high, then valid low.
    task automatic run_read(input int dly, input int n_drive, input bit mid_start);
        int         s0, s180, w;
        logic [1:0] e_err;
        model(n_drive);
        pulse_start_and_check();
        repeat (dly) @(negedge clk0);
        for (int k = 0; k <= n_drive; k++) begin
            for (int p = 0; p < 4; p++) chk($sformatf("score%0d_k%0d", p * 90, k), dut_score(p), pre[p][k]);
            if (k > 0 && k < n_drive) chk("busy_run", calib_busy, 1);
            calib_start = (mid_start && k == 20);
            if (k < n_drive) begin
                calib_rd_valid = 1'b1;
                rise_0 = stream[0][k]; rise_90 = stream[1][k];
                rise_180 = stream[2][k]; rise_270 = stream[3][k];
                @(negedge clk0);
            end else begin
                calib_rd_valid = 1'b0;
                rise_0 = '0; rise_90 = '0; rise_180 = '0; rise_270 = '0;
            end
        end
        for (int i = 0; i < 20 && !calib_done; i++) @(negedge clk0);
        chk("done_seen", calib_done, 1);
        chk("busy_end", calib_busy, 0);
        chk("req_end", calib_rd_req, 0);
        for (int p = 0; p < 4; p++) chk($sformatf("final_score%0d", p * 90), dut_score(p), pre[p][n_drive]);
        if (n_drive == L) begin
            s0 = pre[0][L]; s180 = pre[2][L];
            w  = (s0 >= s180) ? s0 : s180;
            if (w >= THR) begin
                model_sel = (s0 >= s180);
                e_err = 2'b00;
            end else begin
                e_err = 2'b11;
            end
            chk("err_full", calib_err, e_err);
            chk("iddr_keep", dq_iddr_rst, 0);
        end else begin
            chk("err_drop", calib_err, 2'b10);
            chk("iddr_fail", dq_iddr_rst, 1);
        end
        chk("sel", calib_clk0_sel, model_sel);
    endtask

    initial begin
        int cnt;
        rand_rate      = 8;
        rst0           = 1'b1;
        calib_start    = 1'b0;
        calib_rd_valid = 1'b0;
        rise_0 = '0; rise_90 = '0; rise_180 = '0; rise_270 = '0;
        model_sel      = 1'b1;

        tab[0] = '{K_ALT,   K_ALT,  K_MIX,   K_CONST,  64,  0, 1'b1, 2'b00};
        tab[1] = '{K_CONST, K_MIX,  K_ALT,   K_ALT,     0, 64, 1'b0, 2'b00};
        tab[2] = '{K_ALT,   K_RAND, K_ALT,   K_RAND,   64, 64, 1'b1, 2'b00};
        tab[3] = '{K_CONST, K_ALT,  K_ALT,   K_MIX,     0, 64, 1'b0, 2'b00};
        tab[4] = '{K_GLITCH, K_ALT, K_GLITCH, K_GLITCH, 44, 44, 1'b0, 2'b11};

        // Reset values.
        repeat (3) @(negedge clk0);
        chk("rst_iddr", dq_iddr_rst, 1);
        chk("rst_sel", calib_clk0_sel, 1);
        chk("rst_req", calib_rd_req, 0);
        chk("rst_busy", calib_busy, 0);
        chk("rst_done", calib_done, 0);
        chk("rst_err", calib_err, 0);
        chk("rst_s0", score_0, 0);
        chk("rst_s180", score_180, 0);
        rst0 = 1'b0;
        repeat (2) @(negedge clk0);

        // Directed pattern table.
        for (int t = 0; t < 5; t++) begin
            fill(tab[t].k0, tab[t].k90, tab[t].k180, tab[t].k270);
            run_read(10, L, 1'b0);
            chk($sformatf("tab%0d_s0", t), score_0, tab[t].e_s0);
            chk($sformatf("tab%0d_s180", t), score_180, tab[t].e_s180);
            chk($sformatf("tab%0d_sel", t), calib_clk0_sel, tab[t].e_sel);
            chk($sformatf("tab%0d_err", t), calib_err, tab[t].e_err);
        end

        // Valid drops after 20 scored cycles, with an ignored start mid-SCORE.
        fill(K_ALT, K_ALT, K_ALT, K_MIX);
        run_read(3, 1 + SKIP + 20, 1'b1);
        chk("drop_s0", score_0, 20);

        // Valid never arrives: timeout after TMO WAIT cycles.
        @(negedge clk0); calib_start = 1'b1;
        @(negedge clk0); calib_start = 1'b0;
        cnt = 1;
        while (!calib_done && cnt < TMO + 50) begin
            @(negedge clk0);
            cnt++;
            if (cnt == TMO) chk("tmo_req_held", calib_rd_req, 1);
        end
        // ARM + TMO wait cycles + FAIL + one cycle for the registered flag.
        chk("tmo_latency", cnt, TMO + 3);
        chk("tmo_err", calib_err, 2'b01);
        chk("tmo_req", calib_rd_req, 0);
        chk("tmo_iddr", dq_iddr_rst, 1);
        chk("tmo_done", calib_done, 1);
        chk("tmo_sel", calib_clk0_sel, model_sel);

        // Asynchronous reset in SCORE.
        fill(K_ALT, K_ALT, K_ALT, K_ALT);
        pulse_start_and_check();
        for (int k = 0; k < 30; k++) begin
            calib_rd_valid = 1'b1;
            rise_0 = stream[0][k]; rise_90 = stream[1][k];
            rise_180 = stream[2][k]; rise_270 = stream[3][k];
            @(negedge clk0);
        end
        chk("pre_rst_s0", score_0, 30 - 1 - SKIP);
        #2 rst0 = 1'b1;
        #1;
        chk("arst_req", calib_rd_req, 0);
        chk("arst_iddr", dq_iddr_rst, 1);
        chk("arst_busy", calib_busy, 0);
        chk("arst_s0", score_0, 0);
        chk("arst_s180", score_180, 0);
        chk("arst_sel", calib_clk0_sel, 1);
        model_sel = 1'b1;
        calib_rd_valid = 1'b0;
        @(negedge clk0); rst0 = 1'b0;
        @(negedge clk0);
        fill(K_CONST, K_MIX, K_ALT, K_ALT);
        run_read(5, L, 1'b0);
        chk("post_rst_sel", calib_clk0_sel, 0);

        // Randomized reads, corruption rate varied so some runs fall below threshold.
        for (int r = 0; r < 8; r++) begin
            rand_rate = 2 + int'($urandom_range(0, 10));
            fill(K_RAND, K_RAND, K_RAND, K_RAND);
            run_read(int'($urandom_range(0, 12)), L, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nand_phy_rd_calib.md
Name: nand_phy_rd_calib

Overview:
- Read-capture calibration sequencer for one NAND DQ byte lane.
- After power-up, or on request, it holds the lane's IDDR capture in reset, then requests a training read from the command sequencer.
- During the read it scores the four phase samples (0/90/180/270) of every DQ bit against an alternating 0x00/0xFF rise pattern.
- It then drives the lane-wide calib_clk0_sel capture-phase select and the IDDR clock-enable reset (dq_iddr_rst) into the DQ IOBs.

Parameters:
- DQ_WIDTH, 8, number of DQ bits in the lane.
- N_SAMPLES, 64, number of scored clk0 cycles per training read (2..255).
- SKIP_CYCLES, 4, valid cycles discarded before scoring starts (0..15).
- TIMEOUT, 1023, maximum clk0 cycles to wait for calib_rd_valid.
- PASS_THRESH, 56, minimum winning score for success (<= N_SAMPLES-1).

Ports:
- clk0  in  1  system clock, all logic on posedge.
- rst0  in  1  asynchronous active-high reset.
- calib_start  in  1  one-cycle pulse that starts calibration.
- calib_rd_req  out  1  request to the command sequencer for a training read.
- calib_rd_valid  in  1  high while the phase samples carry training data.
- calib_dq_rise_0  in  DQ_WIDTH  phase-0 rise samples, one bit per DQ.
- calib_dq_rise_90  in  DQ_WIDTH  phase-90 rise samples.
- calib_dq_rise_180  in  DQ_WIDTH  phase-180 rise samples.
- calib_dq_rise_270  in  DQ_WIDTH  phase-270 rise samples.
- dq_iddr_rst  out  1  IDDR capture disable, broadcast to the lane.
- calib_clk0_sel  out  1  capture phase select: 1 = phase 0, 0 = phase 180.
- calib_busy  out  1  calibration in progress.
- calib_done  out  1  last calibration finished; sticky until the next start.
- calib_err  out  2  status: 00 ok, 01 timeout, 10 valid dropped, 11 low score.
- score_0, score_90, score_180, score_270  out  8 each  final per-phase scores.

Behaviour:
- Reset values:
  - dq_iddr_rst=1, calib_clk0_sel=1, calib_rd_req=0.
  - calib_busy=0, calib_done=0, calib_err=00, all scores 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: calib_start -> ARM. Sets busy=1, done=0, err=00, clears scores, previous-sample registers and counters.
  - ARM: one cycle. dq_iddr_rst<=0 and calib_rd_req<=1 together, -> WAIT.
  - WAIT: timeout counter increments each cycle.
    - calib_rd_valid=1 -> SKIP, with req held.
    - Counter reaching TIMEOUT -> FAIL with err=01.
  - SKIP: discards SKIP_CYCLES valid cycles, then -> SCORE.
    - If SKIP_CYCLES=0, go straight to SCORE.
    - The last skipped sample loads the previous-sample registers.
  - SCORE: each cycle with valid=1 scores the sample and increments the sample counter.
    - valid=0 before N_SAMPLES scored -> FAIL with err=10.
    - N_SAMPLES scored -> DECIDE.
  - DECIDE: one cycle. calib_rd_req<=0.
    - Winner = phase 0 if score_0 >= score_180, else phase 180. A tie goes to phase 0.
    - Winning score >= PASS_THRESH: calib_clk0_sel<=winner (1 for phase 0, 0 for phase 180), err=00.
    - Otherwise calib_clk0_sel is unchanged and err=11.
    - -> DONE.
  - FAIL: calib_rd_req<=0, dq_iddr_rst<=1, calib_clk0_sel unchanged, -> DONE.
  - DONE: busy=0, done=1. calib_start -> ARM, same clear actions as IDLE.
- Scoring, per phase, per scored cycle. Score +1 when both hold:
  - all DQ_WIDTH bits of the sample are equal, and
  - sample == ~previous sample of that phase.
  - The previous sample updates every scored cycle, whether or not it scores.
  - Scores saturate at 255. Maximum reachable is N_SAMPLES.
- The 90 and 270 scores are diagnostic only; they never affect the select.
- dq_iddr_rst stays 0 after a successful or low-score calibration; it returns to 1 only on FAIL or reset.
- calib_start is ignored while busy.
- rst0 mid-operation aborts immediately to reset values. Any in-flight read request drops.
- Latency: calib_rd_req rises 2 cycles after calib_start. A score update is visible 1 cycle after its valid sample.

Test Plan:
- Start; valid after 10 cycles. Phase 0 alternates 0x00/0xFF; phase 180 shows mixed bits (e.g. 0x0F) -> score_0=64, score_180=0, calib_clk0_sel=1, err=00, done=1, dq_iddr_rst=0.
- Phase 180 clean, phase 0 repeats the same value every cycle -> score_180=64, score_0=0, calib_clk0_sel=0, err=00.
- Both phases clean -> tie, calib_clk0_sel=1. Both phases clean but 10 glitched cycles on each -> scores below 56, err=11, select unchanged.
- Valid never asserted -> err=01 after 1023 WAIT cycles, calib_rd_req=0, dq_iddr_rst=1, done=1.
- Valid drops after 20 scored cycles -> err=10. calib_start pulsed mid-SCORE -> ignored.
- rst0 asserted in SCORE -> all outputs return to reset values asynchronously. A following start produces a clean run.
